// File: rtl/lab3_qsys_onchip_memory_arbiter_if.sv
// Avalon-MM pipelined master bundle: one instance per master port of the
// on-chip memory arbiter. The master side drives the command; the slave
// side (the arbiter) drives waitrequest, read return and the sticky error.
interface lab3_qsys_onchip_memory_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              err;

    // Handshake: a command (read or write high) is accepted on the rising
    // edge where waitrequest is low; while waitrequest is high the master
    // holds address, byteenable, read, write and writedata stable. Read data
    // arrives exactly one cycle after acceptance, qualified by readdatavalid.
    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid, err
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid, err
    );
endinterface

// File: rtl/lab3_qsys_onchip_memory_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM with
// one-cycle read latency. One access is granted per cycle; out-of-range
// accesses are accepted but never reach the RAM, read back as zero and set
// a sticky per-master error flag.
module lab3_qsys_onchip_memory_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4,
    parameter int DEPTH  = 10000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    lab3_qsys_onchip_memory_arbiter_if.slave m0,
    lab3_qsys_onchip_memory_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [BE_W-1:0]      mem_byteenable,
    output logic                 mem_chipselect,
    output logic                 mem_write,
    output logic [DATA_W-1:0]    mem_writedata,
    output logic                 mem_clken,
    input  logic [DATA_W-1:0]    mem_readdata
);

    // last: which master won the most recent grant (1 after reset so that
    // master 0 wins the first contention).
    logic        last_q;
    logic        req0, req1;
    logic        grant0, grant1, grant_any;
    logic        sel_write;
    logic        in_range;
    logic [31:0] sel_addr_ext;

    // Read return pipeline, loaded every cycle from the current grant.
    logic        rd_valid_q;
    logic        rd_owner_q;
    logic        rd_oor_q;
    logic [DATA_W-1:0] ret_data;

    logic        err0_q, err1_q;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    // Round robin: under contention the master that did not win last time.
    assign grant0    = req0 & (~req1 | last_q);
    assign grant1    = req1 & (~req0 | ~last_q);
    assign grant_any = grant0 | grant1;

    assign m0.waitrequest = req0 & ~grant0;
    assign m1.waitrequest = req1 & ~grant1;

    // Command mux: master 0's fields unless master 1 holds the grant.
    always_comb begin
        mem_address    = m0.address;
        mem_byteenable = m0.byteenable;
        mem_writedata  = m0.writedata;
        sel_write      = m0.write;
        if (grant1) begin
            mem_address    = m1.address;
            mem_byteenable = m1.byteenable;
            mem_writedata  = m1.writedata;
            sel_write      = m1.write;
        end
    end

    // Compare in 32 bits so DEPTH may equal 2**ADDR_W without wrapping.
    assign sel_addr_ext = 32'(mem_address);
    assign in_range     = sel_addr_ext < 32'(DEPTH);

    assign mem_chipselect = grant_any & in_range;
    assign mem_write      = grant_any & in_range & sel_write;
    assign mem_clken      = 1'b1;

    // Round-robin pointer follows every grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (grant_any) begin
            last_q <= grant1;
        end
    end

    // Read return pipeline: read+write together counts as a write (no return).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_owner_q <= 1'b0;
            rd_oor_q   <= 1'b0;
        end else begin
            rd_valid_q <= grant_any & ~sel_write;
            rd_owner_q <= grant1;
            rd_oor_q   <= ~in_range;
        end
    end

    // Sticky out-of-range flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            if (grant0 && !in_range) err0_q <= 1'b1;
            if (grant1 && !in_range) err1_q <= 1'b1;
        end
    end

    // RAM q is masked unless a valid in-range read is returning.
    assign ret_data = (rd_valid_q && !rd_oor_q) ? mem_readdata : '0;

    assign m0.readdata      = ret_data;
    assign m1.readdata      = ret_data;
    assign m0.readdatavalid = rd_valid_q & ~rd_owner_q;
    assign m1.readdatavalid = rd_valid_q & rd_owner_q;
    assign m0.err           = err0_q;
    assign m1.err           = err1_q;

endmodule

// File: tb/tb_lab3_qsys_onchip_memory_arbiter.sv
// Bench for the two-master on-chip memory arbiter: behavioural RAM attached
// to the mem_* port, a reference model of arbitration/memory/returns, then
// directed scenarios followed by randomized traffic.
module tb_lab3_qsys_onchip_memory_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int DEPTH  = 10000;

    typedef struct packed {
        logic              r;
        logic              w;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } cmd_t;

    logic              clk;
    logic              reset_n;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    lab3_qsys_onchip_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m0_bus ();
    lab3_qsys_onchip_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m1_bus ();

    lab3_qsys_onchip_memory_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0_bus),
        .m1             (m1_bus),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural RAM ----------------
    logic [DATA_W-1:0] ram [0:DEPTH-1];
    logic [DATA_W-1:0] mem_q;
    assign mem_readdata = mem_q;

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect && (int'(mem_address) < DEPTH)) begin
            if (mem_write) begin
                for (int b = 0; b < BE_W; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            mem_q <= ram[mem_address];
        end
    end

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
    logic [DATA_W-1:0] exp_q [$];
    int                exp_own_q [$];
    int                m_last;
    logic              m_err [2];

    int                n_checks;
    int                n_pass;
    logic [DATA_W-1:0] obs_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_own_q.delete();
        m_last   = 1;
        m_err[0] = 1'b0;
        m_err[1] = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input cmd_t c0, input cmd_t c1);
        m0_bus.read = c0.r; m0_bus.write = c0.w; m0_bus.address = c0.addr;
        m0_bus.byteenable = c0.be; m0_bus.writedata = c0.data;
        m1_bus.read = c1.r; m1_bus.write = c1.w; m1_bus.address = c1.addr;
        m1_bus.byteenable = c1.be; m1_bus.writedata = c1.data;
    endtask

    // One bus cycle: present commands, check everything at the falling edge
    // against the model, update the model, then advance past the next edge.
    task automatic step(input cmd_t c0, input cmd_t c1, output logic g0, output logic g1);
        cmd_t  cw;
        int    win;
        logic  req0, req1, in_r;
        logic [DATA_W-1:0] e_data;
        int    e_own;
        drive(c0, c1);
        @(negedge clk);
        req0 = c0.r | c0.w;
        req1 = c1.r | c1.w;
        win = -1;
        if (req0 && req1) win = (m_last == 0) ? 1 : 0;
        else if (req0)    win = 0;
        else if (req1)    win = 1;

        check("m0_waitrequest", 32'(m0_bus.waitrequest), 32'(req0 && win != 0));
        check("m1_waitrequest", 32'(m1_bus.waitrequest), 32'(req1 && win != 1));
        check("mem_clken", 32'(mem_clken), 32'd1);

        if (exp_q.size() > 0) begin
            e_data = exp_q.pop_front();
            e_own  = exp_own_q.pop_front();
            check("m0_readdatavalid", 32'(m0_bus.readdatavalid), 32'(e_own == 0));
            check("m1_readdatavalid", 32'(m1_bus.readdatavalid), 32'(e_own == 1));
        end else begin
            e_data = '0;
            check("m0_readdatavalid", 32'(m0_bus.readdatavalid), 32'd0);
            check("m1_readdatavalid", 32'(m1_bus.readdatavalid), 32'd0);
        end
        check("m0_readdata", m0_bus.readdata, e_data);
        check("m1_readdata", m1_bus.readdata, e_data);
        obs_rd = m0_bus.readdata;
        check("m0_err", 32'(m0_bus.err), 32'(m_err[0]));
        check("m1_err", 32'(m1_bus.err), 32'(m_err[1]));

        if (win >= 0) begin
            cw   = (win == 0) ? c0 : c1;
            in_r = int'(cw.addr) < DEPTH;
            check("mem_chipselect", 32'(mem_chipselect), 32'(in_r));
            check("mem_write", 32'(mem_write), 32'(in_r && cw.w));
            if (in_r) begin
                check("mem_address", 32'(mem_address), 32'(cw.addr));
                if (cw.w) begin
                    check("mem_byteenable", 32'(mem_byteenable), 32'(cw.be));
                    check("mem_writedata", mem_writedata, cw.data);
                end
            end
            m_last = win;
            if (!in_r) m_err[win] = 1'b1;
            if (cw.w) begin
                if (in_r)
                    for (int b = 0; b < BE_W; b++)
                        if (cw.be[b]) ref_mem[cw.addr][8*b +: 8] = cw.data[8*b +: 8];
            end else begin
                exp_q.push_back(in_r ? ref_mem[cw.addr] : '0);
                exp_own_q.push_back(win);
            end
        end else begin
            check("mem_chipselect_idle", 32'(mem_chipselect), 32'd0);
            check("mem_write_idle", 32'(mem_write), 32'd0);
        end
        g0 = (win == 0);
        g1 = (win == 1);
        @(posedge clk);
        #1;
    endtask

    function automatic cmd_t mk(input logic r, input logic w, input int a,
                                input logic [3:0] be, input logic [31:0] d);
        cmd_t c;
        c.r = r; c.w = w; c.addr = ADDR_W'(a); c.be = be; c.data = d;
        return c;
    endfunction

    task automatic do_reset();
        cmd_t idle;
        idle = mk(0, 0, 0, 4'h0, 32'h0);
        drive(idle, idle);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_m0_rdv", 32'(m0_bus.readdatavalid), 32'd0);
        check("rst_m1_rdv", 32'(m1_bus.readdatavalid), 32'd0);
        check("rst_m0_readdata", m0_bus.readdata, 32'h0);
        check("rst_m0_err", 32'(m0_bus.err), 32'd0);
        check("rst_m1_err", 32'(m1_bus.err), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_clear();
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        cmd_t idle, p0, p1;
        logic g0, g1, v0, v1;
        int   k, bad;
        n_checks = 0;
        n_pass   = 0;
        obs_rd   = '0;
        idle = mk(0, 0, 0, 4'h0, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = 32'(i) * 32'h01010101 ^ 32'hC3C3_0000;
            ref_mem[i] = 32'(i) * 32'h01010101 ^ 32'hC3C3_0000;
        end
        ram[1] = 32'hA1; ref_mem[1] = 32'hA1;
        ram[2] = 32'hA2; ref_mem[2] = 32'hA2;
        mem_q = '0;
        reset_n = 1'b1;
        drive(idle, idle);
        #2;
        do_reset();
        step(idle, idle, g0, g1);

        // write then read back on consecutive cycles
        step(mk(0, 1, 5, 4'hF, 32'h12345678), idle, g0, g1);
        check("wr5_grant", 32'(g0), 32'd1);
        step(mk(1, 0, 5, 4'h0, 32'h0), idle, g0, g1);
        check("rd5_grant", 32'(g0), 32'd1);
        step(idle, idle, g0, g1);
        check("rd5_data", obs_rd, 32'h12345678);

        // continuous contention alternates starting with m0
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step(mk(1, 0, 1, 4'h0, 32'h0), mk(1, 0, 2, 4'h0, 32'h0), g0, g1);
            check("alt_grant_m0", 32'(g0), 32'(c % 2 == 0));
            check("alt_grant_m1", 32'(g1), 32'(c % 2 == 1));
        end
        step(idle, idle, g0, g1);

        // byte-enable merge
        step(mk(0, 1, 7, 4'hF, 32'hFFFFFFFF), idle, g0, g1);
        step(mk(0, 1, 7, 4'h5, 32'h00000000), idle, g0, g1);
        step(mk(1, 0, 7, 4'h0, 32'h0), idle, g0, g1);
        step(idle, idle, g0, g1);
        check("be_merge", obs_rd, 32'hFF00FF00);

        // out-of-range accesses from m1
        step(idle, mk(0, 1, 10000, 4'hF, 32'hDEADBEEF), g0, g1);
        step(idle, mk(1, 0, 12000, 4'h0, 32'h0), g0, g1);
        step(idle, idle, g0, g1);
        step(idle, idle, g0, g1);
        check("m1_err_sticky", 32'(m1_bus.err), 32'd1);
        check("m0_err_clear", 32'(m0_bus.err), 32'd0);

        // reset pulse while a read is in flight drops the return
        step(mk(1, 0, 5, 4'h0, 32'h0), idle, g0, g1);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        model_clear();
        step(idle, idle, g0, g1);
        step(mk(1, 0, 1, 4'h0, 32'h0), mk(1, 0, 2, 4'h0, 32'h0), g0, g1);
        check("post_reset_first_m0", 32'(g0), 32'd1);
        step(idle, idle, g0, g1);

        // read and write together counts as a write
        step(mk(1, 1, 3, 4'hF, 32'h00000055), idle, g0, g1);
        step(idle, idle, g0, g1);
        step(mk(1, 0, 3, 4'h0, 32'h0), idle, g0, g1);
        step(idle, idle, g0, g1);
        check("rw_both_data", obs_rd, 32'h00000055);

        // randomized traffic; masters hold commands until accepted
        v0 = 1'b0; v1 = 1'b0; p0 = idle; p1 = idle;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (!v0 && $urandom_range(0, 3) != 0) begin
                k  = $urandom_range(0, 9);
                p0 = mk(k < 5 || k == 9, k >= 5, ($urandom_range(0, 19) == 0) ?
                        $urandom_range(10000, 16383) : $urandom_range(0, 31),
                        4'($urandom_range(0, 15)), $urandom);
                v0 = 1'b1;
            end
            if (!v1 && $urandom_range(0, 3) != 0) begin
                k  = $urandom_range(0, 9);
                p1 = mk(k < 5 || k == 9, k >= 5, ($urandom_range(0, 19) == 0) ?
                        $urandom_range(10000, 16383) : $urandom_range(0, 31),
                        4'($urandom_range(0, 15)), $urandom);
                v1 = 1'b1;
            end
            step(v0 ? p0 : idle, v1 ? p1 : idle, g0, g1);
            if (g0) v0 = 1'b0;
            if (g1) v1 = 1'b0;
        end
        step(idle, idle, g0, g1);
        step(idle, idle, g0, g1);

        // RAM contents must match the model everywhere
        bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (ram[i] !== ref_mem[i]) bad++;
        check("ram_contents_mismatches", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lab3_qsys_onchip_memory_arbiter.md
# lab3_qsys_onchip_memory_arbiter

Two-master round-robin arbiter that shares the single-port 32-bit on-chip RAM (10000 words, 14-bit word address, byte enables, one-cycle read latency) between two Avalon-MM pipelined masters. It sits between the masters and the RAM's s1 slave port. It grants at most one access per cycle, steers read data back to the issuing master with `readdatavalid`, and blocks out-of-range addresses before they reach the RAM.

## Interface
- `ADDR_W`, 14, word address width
- `DATA_W`, 32, data width
- `BE_W`, 4, byte-enable width (`DATA_W`/8)
- `DEPTH`, 10000, number of implemented RAM words; addresses ≥ `DEPTH` are out of range
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `m0_address` / `m1_address`  in  `ADDR_W`  master word address
- `m0_byteenable` / `m1_byteenable`  in  `BE_W`  byte lanes for writes
- `m0_read` / `m1_read`  in  1  read request
- `m0_write` / `m1_write`  in  1  write request
- `m0_writedata` / `m1_writedata`  in  `DATA_W`  write data
- `m0_waitrequest` / `m1_waitrequest`  out  1  request is held, not accepted this cycle
- `m0_readdata` / `m1_readdata`  out  `DATA_W`  read return data
- `m0_readdatavalid` / `m1_readdatavalid`  out  1  readdata valid this cycle
- `m0_err` / `m1_err`  out  1  sticky: master issued an out-of-range access
- `mem_address`  out  `ADDR_W`  RAM address
- `mem_byteenable`  out  `BE_W`  RAM byte enables
- `mem_chipselect`  out  1  RAM select
- `mem_write`  out  1  RAM write
- `mem_writedata`  out  `DATA_W`  RAM write data
- `mem_clken`  out  1  RAM clock enable; constant 1
- `mem_readdata`  in  `DATA_W`  RAM q, valid one cycle after the address is presented

## Operation
- A request from master i is `mi_read | mi_write`. If both are high, the access is a write and returns no read data.
- Grant is combinational from the current requests and the registered `last` pointer (0 or 1):
  - Only one master requests: that master is granted.
  - Both request: the master ≠ `last` is granted.
  - On every grant, `last` ← the granted master.
- `mi_waitrequest` = request_i & ~grant_i. A master must hold its command stable while waitrequest is high.
- Granted in-range access (`address < DEPTH`): `mem_chipselect` = 1, `mem_write` = granted write, and address, byteenable and writedata are muxed from the winner.
- When nothing is granted, or the access is out of range: `mem_chipselect` = 0, `mem_write` = 0. The mux holds master 0's fields; they are don't-care.
- Out-of-range access:
  - It is accepted (waitrequest low when granted), and the write is dropped.
  - A read returns 0x00000000.
  - `mi_err` sets and stays set until reset.
- Read return path is a one-entry pipeline register {valid, owner, oor}, loaded every cycle from the current grant.
  - Next cycle, `m<owner>_readdatavalid` = valid.
  - Readdata = `mem_readdata`, or 0 if oor.
  - The non-owner's readdatavalid is 0.
  - Both `mi_readdata` buses carry that same value.
- A new access can be granted in the same cycle a previous read returns. Full throughput is one access per cycle.

## Timing
- Reset (`reset_n` low, asynchronous):
  - `last` = 1, so master 0 wins the first contention.
  - Return pipeline valid = 0, `mi_readdatavalid` = 0, `mi_err` = 0.
  - `mi_readdata` = 0, because `mem_readdata` is masked while not valid.
  - Combinational outputs follow the inputs.
- Grant latency 0: a request is accepted in the cycle it is presented, if it wins.
- Read latency 1: read accepted at edge N, `readdatavalid` high in cycle N+1 only.
- Write: RAM written at edge N; no response.
- Two continuously requesting masters alternate grants every cycle, m0, m1, m0, …
- A master is never starved for more than 1 cycle.
- Reset asserted mid-read: the pending readdatavalid is dropped and never delivered. The first grant after release goes per the `last` = 1 rule.
- Write then read of the same address on consecutive cycles returns the new data (RAM write completes at edge N, read sampled at N+1).

## Test plan
- Reset, then m0 writes 0x12345678 to addr 5 with BE=0xF, then reads addr 5 → m0_waitrequest low both cycles; m0_readdatavalid high exactly 1 cycle later with 0x12345678; m1_readdatavalid stays 0.
- m0 and m1 read addrs 1 and 2 continuously for 6 cycles, preloaded 0xA1/0xA2 → grants alternate starting with m0; each master sees waitrequest every other cycle and readdatavalid on the alternate cycles with the correct data.
- Byte-enable merge: write 0xFFFFFFFF, then write 0x00000000 with BE=0x5, then read → 0xFF00FF00.
- m1 writes addr 10000, then reads addr 12000 → `mem_chipselect` stays 0, RAM unchanged, read returns 0x0 after 1 cycle, m1_err = 1 and stays 1, m0_err = 0.
- m0 issues a read, and `reset_n` pulses low before the return cycle → no readdatavalid is seen; after release, simultaneous requests grant m0 first.
- m0 with read and write both high to addr 3 with data 0x55 → RAM addr 3 written with 0x55, no readdatavalid.
